// File: rtl/clock_divider.sv
// Free-running binary clock divider with a selectable tap, tap rising-edge
// detector and a programmable terminal-count divider producing a tick and a 50% clock.
module clock_divider #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] DIV_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
    input  logic [4:0]       tap_sel,
    output logic [WIDTH-1:0] clk_div,
    output logic             tap_out,
    output logic             tap_rise,
    output logic             div_tick,
    output logic             div_clk
);

    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] div_cnt;
    logic             div_term;
    logic             tap_prev;
    logic [4:0]       sel_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div <= '0;
        end else if (clr) begin
            clk_div <= '0;
        end else if (en) begin
            clk_div <= clk_div + WIDTH'(1);
        end
    end

    assign div_term = (div_cnt == div_reg);

    // A load restarts the divide phase but leaves div_clk where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= DIV_INIT;
            div_cnt  <= '0;
            div_tick <= 1'b0;
            div_clk  <= 1'b0;
        end else begin
            if (div_load) begin
                div_reg <= div_val;
            end
            if (clr) begin
                div_cnt  <= '0;
                div_tick <= 1'b0;
                div_clk  <= 1'b0;
            end else if (div_load) begin
                div_cnt  <= '0;
                div_tick <= 1'b0;
            end else if (en) begin
                if (div_term) begin
                    div_cnt  <= '0;
                    div_tick <= 1'b1;
                    div_clk  <= ~div_clk;
                end else begin
                    div_cnt  <= div_cnt + WIDTH'(1);
                    div_tick <= 1'b0;
                end
            end else begin
                div_tick <= 1'b0;
            end
        end
    end

    // Selects out of range of the counter read as a constant 0.
    always_comb begin
        tap_out = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(tap_sel) == i) begin
                tap_out = clk_div[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_prev <= 1'b0;
            sel_prev <= '0;
        end else begin
            tap_prev <= tap_out;
            sel_prev <= tap_sel;
        end
    end

    assign tap_rise = tap_out & ~tap_prev & (sel_prev == tap_sel);

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider (WIDTH=8): a stimulus process feeds directed
// and random cycles to an arithmetic reference model; a monitor compares each cycle.
module tb_clock_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic         div_load;
    logic [W-1:0] div_val;
    logic [4:0]   tap_sel;
    logic [W-1:0] clk_div;
    logic         tap_out;
    logic         tap_rise;
    logic         div_tick;
    logic         div_clk;

    clock_divider #(.WIDTH(W), .DIV_INIT(8'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .div_load (div_load),
        .div_val  (div_val),
        .tap_sel  (tap_sel),
        .clk_div  (clk_div),
        .tap_out  (tap_out),
        .tap_rise (tap_rise),
        .div_tick (div_tick),
        .div_clk  (div_clk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int   cnt;
        logic tick;
        logic dclk;
        logic tout;
        logic trise;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int fails  = 0;

    // Reference model: counts in plain integers, the divider as enabled steps
    // since the last restart, ticking on every multiple of the period.
    int   m_cnt, m_reg, m_steps, m_sprev;
    logic m_tick, m_dclk, m_tprev;
    int   h_en, h_clr, h_load, h_val, h_sel;

    function automatic logic tap_fn(input int cnt, input int sel);
        if (sel >= W) return 1'b0;
        return logic'((cnt >> sel) & 1);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_reg = 0; m_steps = 0; m_sprev = 0;
        m_tick = 0; m_dclk = 0; m_tprev = 0;
    endtask

    task automatic model_edge();
        logic old_tap;
        old_tap = tap_fn(m_cnt, h_sel);
        if (h_clr != 0) m_cnt = 0;
        else if (h_en != 0) m_cnt = (m_cnt + 1) % 256;
        if (h_clr != 0) begin
            m_steps = 0; m_tick = 0; m_dclk = 0;
            if (h_load != 0) m_reg = h_val;
        end else if (h_load != 0) begin
            m_reg = h_val; m_steps = 0; m_tick = 0;
        end else if (h_en != 0) begin
            m_steps++;
            m_tick = ((m_steps % (m_reg + 1)) == 0);
            if (m_tick) m_dclk = ~m_dclk;
        end else begin
            m_tick = 0;
        end
        m_tprev = old_tap;
        m_sprev = h_sel;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input int e, input int c, input int l, input int v, input int s);
        exp_t x;
        @(posedge clk);
        model_edge();
        #1;
        en = e[0]; clr = c[0]; div_load = l[0]; div_val = v[W-1:0]; tap_sel = s[4:0];
        h_en = e; h_clr = c; h_load = l; h_val = v % 256; h_sel = s % 32;
        x.cnt   = m_cnt;
        x.tick  = m_tick;
        x.dclk  = m_dclk;
        x.tout  = tap_fn(m_cnt, h_sel);
        x.trise = x.tout & ~m_tprev & (m_sprev == h_sel);
        exp_q.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_clk_div"}, int'(clk_div), 0);
        check_output({tag, "_div_tick"}, int'(div_tick), 0);
        check_output({tag, "_div_clk"}, int'(div_clk), 0);
        check_output({tag, "_tap_out"}, int'(tap_out), 0);
        check_output({tag, "_tap_rise"}, int'(tap_rise), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        en = 0; clr = 0; div_load = 0; div_val = '0;
        h_en = 0; h_clr = 0; h_load = 0; h_val = 0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs, compared mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check_output("clk_div", int'(clk_div), x.cnt);
                check_output("div_tick", int'(div_tick), int'(x.tick));
                check_output("div_clk", int'(div_clk), int'(x.dclk));
                check_output("tap_out", int'(tap_out), int'(x.tout));
                check_output("tap_rise", int'(tap_rise), int'(x.trise));
            end
        end
    end

    initial begin
        int sel;
        rst_n = 1'b0;
        en = 0; clr = 0; div_load = 0; div_val = '0; tap_sel = '0;
        h_en = 0; h_clr = 0; h_load = 0; h_val = 0; h_sel = 0;
        model_reset();
        #3;
        check_all_zero("reset");
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 0, 1);
        apply_stimulus(0, 0, 1, 4, 1);
        for (int i = 0; i < 30; i++) apply_stimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 22; i++) apply_stimulus(1, 0, 0, 0, 2);
        for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 31);
        apply_stimulus(1, 0, 1, 0, 7);
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 0, 7);
        apply_stimulus(1, 1, 1, 2, 7);
        for (int i = 0; i < 262; i++) apply_stimulus(1, 0, 0, 0, 7);
        for (int i = 0; i < 7; i++) apply_stimulus(1, 0, 0, 0, 3);
        mid_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 3);

        sel = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19) == 0) sel = ($urandom_range(9) == 0) ? 31 : int'($urandom_range(9));
            apply_stimulus(($urandom_range(7) != 0) ? 1 : 0,
                           ($urandom_range(49) == 0) ? 1 : 0,
                           ($urandom_range(39) == 0) ? 1 : 0,
                           int'($urandom_range(11)), sel);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        check_output("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
